mem_scan_ctrl: RTL and testbench
================================

MEM_SCAN_CTRL -- requirements
Module: mem_scan_ctrl

Interface
REQ-001 Parameter LENGTH, default 16: number of words scanned per run; legal range >= 2.
REQ-002 Parameter RD_LAT, default 1: memory read latency in cycles; legal range >= 1.
REQ-003 Parameter DATA_W, default 8: memory data width.
REQ-004 Derived constant ADDR_W = $clog2(LENGTH): address width.
REQ-005 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  request one full scan; accepted only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  single-cycle pulse at the end of a completed scan.
REQ-010 mem_addr  out  ADDR_W  current read address.
REQ-011 mem_rd  out  1  memory read strobe.
REQ-012 mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_rd.
REQ-013 out_data  out  DATA_W  captured word presented downstream.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 out_ready  in  1  downstream accepts the word.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, READ, WAIT, PRESENT, DONE.
REQ-017 IDLE: start=1 -> READ with address 0; start=0 -> stay in IDLE.
REQ-018 READ: mem_rd=1 for exactly one cycle, then -> WAIT.
REQ-019 WAIT: lasts exactly RD_LAT cycles; on the last WAIT cycle, mem_rdata is registered into out_data; then -> PRESENT.
REQ-020 PRESENT: out_valid=1 and out_data held stable until out_valid && out_ready.
REQ-021 On the handshake in PRESENT: address == LENGTH-1 -> DONE; otherwise address+1 -> READ.
REQ-022 DONE: done=1 for one cycle, address cleared to 0, -> IDLE.
REQ-023 mem_addr SHALL hold its value in WAIT and PRESENT and change only on the PRESENT handshake or on clear.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 With out_ready held high, each word SHALL take RD_LAT+2 cycles; out_valid SHALL never stay high for two consecutive cycles.
REQ-027 The last-address compare SHALL be exact (== LENGTH-1); the address SHALL never exceed LENGTH-1 and never wrap during a scan.
REQ-028 mem_rd, out_valid and done SHALL be mutually exclusive in every cycle.

Reset
REQ-029 rst SHALL force IDLE, mem_addr=0, out_data=0, out_valid=0, mem_rd=0, done=0, busy=0, and latency counter=0.
REQ-030 rst asserted mid-scan SHALL abandon the scan immediately, with no done pulse; after rst deasserts, the block SHALL wait for a new start.

Configuration
REQ-031 Macro MEM_SCAN_ABORT_EN defined: an extra input abort (1 bit) SHALL exist; abort=1 in any non-IDLE state SHALL force IDLE on the next edge with mem_addr=0 and out_valid=0, and SHALL NOT pulse done; abort SHALL take priority over the out_ready handshake in the same cycle.
REQ-032 Macro MEM_SCAN_ABORT_EN undefined: the abort port SHALL be absent and the block SHALL behave per REQ-016..REQ-028 only.

Structure
REQ-033 Package mem_scan_pkg SHALL hold the state enumeration and the default values of LENGTH, RD_LAT and DATA_W.
REQ-034 The address register SHALL be a sub-module scan_addr_counter with ports clk, rst, clr, en, addr and last (last = addr == LENGTH-1).
REQ-035 The RD_LAT wait counter SHALL be local to mem_scan_ctrl, with width $clog2(RD_LAT+1).

Verification
REQ-036 LENGTH=4, RD_LAT=1, out_ready=1, start pulsed in cycle 0 -> mem_rd in cycles 1,4,7,10 (addr 0..3); out_valid in cycles 3,6,9,12; done in cycle 13; busy cycles 1-13.
REQ-037 Memory model returns data = addr+8'hA0, RD_LAT=3 -> out_data sequence A0,A1,A2,A3; each word 5 cycles apart.
REQ-038 out_ready low for 4 cycles during the word at addr 1 -> out_valid and out_data=A1 held stable; mem_addr stays 1; no mem_rd until the handshake.
REQ-039 rst asserted in the WAIT state of word 2 -> all outputs 0 in the same cycle; no done pulse; a subsequent start rescans from addr 0.
REQ-040 start re-pulsed while busy -> exactly one done pulse and four words, no second scan.
REQ-041 MEM_SCAN_ABORT_EN defined, abort=1 in the same cycle as the PRESENT handshake at addr 2 -> IDLE next cycle, mem_addr=0, no done pulse.

Source files
------------

// File: rtl/mem_scan_pkg.sv
// Shared state encoding and default sizing for the memory scan controller.
package mem_scan_pkg;

  localparam int unsigned LENGTH_DEF = 16;
  localparam int unsigned RD_LAT_DEF = 1;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } scan_state_e;

endpackage

// File: rtl/scan_addr_counter.sv
// Scan address register: clear has priority, increments saturate at the last word.
module scan_addr_counter #(
  parameter  int unsigned LENGTH = 16,
  localparam int unsigned ADDR_W = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last = (addr_q == LAST_ADDR);
  assign addr = addr_q;

  // NOTE: the hold value is assigned first so every path drives addr_d and no latch is inferred.
  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (en && !last) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/mem_scan_ctrl.sv
// Sequential memory scan: read, wait RD_LAT cycles, present each word downstream.
// Define MEM_SCAN_ABORT_EN to add an abort input that drops any scan back to IDLE.
module mem_scan_ctrl
  import mem_scan_pkg::*;
#(
  parameter  int unsigned LENGTH = LENGTH_DEF,
  parameter  int unsigned RD_LAT = RD_LAT_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned ADDR_W = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef MEM_SCAN_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned      CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              addr_clr, addr_en, addr_last, abort_req;

`ifdef MEM_SCAN_ABORT_EN
  assign abort_req = abort && (state_q != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  scan_addr_counter #(.LENGTH(LENGTH)) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clr  (addr_clr),
    .en   (addr_en),
    .addr (mem_addr),
    .last (addr_last)
  );

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    out_data_d = out_data_q;
    addr_clr   = 1'b0;
    addr_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_READ;
      end
      S_READ: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Count down from RD_LAT; the final WAIT cycle is where read data is valid.
        if (lat_cnt_q == CNT_W'(1)) begin
          out_data_d = mem_rdata;
          lat_cnt_d  = '0;
          state_d    = S_PRESENT;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (addr_last) begin
            state_d = S_DONE;
          end else begin
            addr_en = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        addr_clr = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any handshake taken in the same cycle.
    if (abort_req) begin
      state_d   = S_IDLE;
      addr_clr  = 1'b1;
      addr_en   = 1'b0;
      lat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_rd    = (state_q == S_READ);
  assign out_valid = (state_q == S_PRESENT);
  assign done      = (state_q == S_DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Self-checking bench for mem_scan_ctrl (LENGTH=4, RD_LAT=3): timing model plus directed literals.
module tb_mem_scan_ctrl;

  localparam int LENGTH = 4;
  localparam int RD_LAT = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = $clog2(LENGTH);

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
`ifdef MEM_SCAN_ABORT_EN
  logic              abort;
`endif

  mem_scan_ctrl #(.LENGTH(LENGTH), .RD_LAT(RD_LAT), .DATA_W(DATA_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef MEM_SCAN_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: word = addr + A0, valid exactly RD_LAT cycles after the read strobe, junk otherwise.
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd ? (8'hA0 + DATA_W'(mem_addr)) : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Event log of the DUT, filled while rec_en is set.
  bit   rec_en   = 0;
  int   rec_base = 0;
  int   rd_q[$], v_q[$], done_q[$], rd_addr_q[$];
  logic [DATA_W-1:0] data_q[$];
  int   busy_n   = 0;
  int   done_cnt = 0;
  int   hs_cnt   = 0;

  // Reference model: a scan is a list of words; word w is read at m_rd_cyc, presented from
  // m_rd_cyc+RD_LAT+1 until accepted; the next read (or done) follows the accepting cycle.
  bit m_scan     = 0;
  int m_w        = 0;
  int m_rd_cyc   = 0;
  int m_done_cyc = -1;

  always @(negedge clk) begin
    int   c;
    int   e_addr;
    logic e_rd, e_v, e_done;
    c = cyc;
    if (rst) begin
      m_scan = 0;
      check("rst_busy", busy, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", out_data, 0);
    end else begin
      e_done = m_scan && (c == m_done_cyc);
      e_rd   = m_scan && (m_done_cyc < 0) && (c == m_rd_cyc);
      e_v    = m_scan && (m_done_cyc < 0) && (c >= m_rd_cyc + RD_LAT + 1);
      e_addr = !m_scan ? 0 : ((m_done_cyc >= 0) ? LENGTH - 1 : m_w);
      check("busy", busy, m_scan);
      check("mem_rd", mem_rd, e_rd);
      check("out_valid", out_valid, e_v);
      check("done", done, e_done);
      check("mem_addr", mem_addr, e_addr);
      if (e_v) check("out_data", out_data, 8'(8'hA0 + m_w));

      if (done) done_cnt++;
      if (out_valid && out_ready) hs_cnt++;
      if (rec_en) begin
        if (mem_rd) begin
          rd_q.push_back(c - rec_base);
          rd_addr_q.push_back(int'(mem_addr));
        end
        if (out_valid) v_q.push_back(c - rec_base);
        if (out_valid && out_ready) data_q.push_back(out_data);
        if (done) done_q.push_back(c - rec_base);
        if (busy) busy_n++;
      end

      if (m_scan) begin
`ifdef MEM_SCAN_ABORT_EN
        if (abort) m_scan = 0;
        else
`endif
        if (c == m_done_cyc) m_scan = 0;
        else if (e_v && out_ready) begin
          if (m_w == LENGTH - 1) m_done_cyc = c + 1;
          else begin
            m_w++;
            m_rd_cyc = c + 1;
          end
        end
      end else if (start) begin
        m_scan     = 1;
        m_w        = 0;
        m_rd_cyc   = c + 1;
        m_done_cyc = -1;
      end
    end
  end

  // kind: 0 done, 1 mem_rd at addr a, 2 out_valid, 3 out_valid at addr a
  task automatic wait_for(input string name, input int kind, input int a, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      case (kind)
        0:       hit = done;
        1:       hit = mem_rd && (int'(mem_addr) == a);
        2:       hit = out_valid;
        default: hit = out_valid && (int'(mem_addr) == a);
      endcase
    end
    check(name, hit, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_log();
    rd_q.delete(); v_q.delete(); done_q.delete(); rd_addr_q.delete(); data_q.delete();
    busy_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, h0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
`ifdef MEM_SCAN_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full scan with out_ready high: word spacing RD_LAT+2 = 5.
    clear_log();
    rec_base = cyc;
    rec_en   = 1;
    pulse_start();
    wait_for("a_done_seen", 0, 0, 100);
    @(posedge clk); #1;
    rec_en = 0;
    check("a_rd_count", rd_q.size(), 4);
    check("a_valid_count", v_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("a_rd_cycle%0d", i), (i < rd_q.size()) ? rd_q[i] : -1, 1 + 5 * i);
      check($sformatf("a_valid_cycle%0d", i), (i < v_q.size()) ? v_q[i] : -1, 5 + 5 * i);
      check($sformatf("a_rd_addr%0d", i), (i < rd_addr_q.size()) ? rd_addr_q[i] : -1, i);
      check($sformatf("a_data%0d", i), (i < data_q.size()) ? data_q[i] : 8'h00, 8'hA0 + i);
    end
    check("a_done_count", done_q.size(), 1);
    check("a_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, 21);
    check("a_busy_cycles", busy_n, 21);

    // Back-pressure on word 1: ready dropped before the word appears, held low 4 valid cycles.
    clear_log();
    rec_en = 1;
    pulse_start();
    wait_for("b_read1", 1, 1, 50);
    out_ready = 1'b0;
    wait_for("b_valid1", 2, 0, 20);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_hold_valid%0d", i), out_valid, 1);
      check($sformatf("b_hold_data%0d", i), out_data, 8'hA1);
      check($sformatf("b_hold_addr%0d", i), mem_addr, 1);
      check($sformatf("b_hold_rd%0d", i), mem_rd, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_for("b_done_seen", 0, 0, 100);
    @(posedge clk); #1;
    rec_en = 0;
    check("b_words", data_q.size(), 4);
    check("b_word1", (data_q.size() > 1) ? data_q[1] : 8'h00, 8'hA1);

    // Reset in the WAIT state of word 2, then a fresh scan from address 0.
    d0 = done_cnt;
    pulse_start();
    wait_for("c_read2", 1, 2, 50);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("c_busy", busy, 0);
    check("c_mem_rd", mem_rd, 0);
    check("c_valid", out_valid, 0);
    check("c_done", done, 0);
    check("c_addr", mem_addr, 0);
    check("c_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("c_no_done", done_cnt - d0, 0);
    check("c_idle_after", busy, 0);
    clear_log();
    rec_en = 1;
    d0 = done_cnt;
    pulse_start();
    wait_for("c_done_seen", 0, 0, 100);
    @(posedge clk); #1;
    rec_en = 0;
    check("c_first_addr", (rd_addr_q.size() > 0) ? rd_addr_q[0] : -1, 0);
    check("c_rescan_done", done_cnt - d0, 1);

    // start re-pulsed while busy must not queue a second scan.
    d0 = done_cnt;
    h0 = hs_cnt;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      repeat (2) @(posedge clk);
      #1;
      pulse_start();
    end
    wait_for("d_done_seen", 0, 0, 100);
    repeat (30) @(posedge clk);
    #1;
    check("d_done_pulses", done_cnt - d0, 1);
    check("d_words", hs_cnt - h0, 4);
    check("d_idle", busy, 0);

`ifdef MEM_SCAN_ABORT_EN
    // Abort coinciding with the handshake at address 2.
    d0 = done_cnt;
    pulse_start();
    wait_for("e_valid2", 3, 2, 50);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("e_busy", busy, 0);
    check("e_addr", mem_addr, 0);
    check("e_valid", out_valid, 0);
    repeat (5) @(posedge clk);
    #1;
    check("e_no_done", done_cnt - d0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
